// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end for one shared pipelined CORDIC rotator, with a
// requester tag pipe and a credit-guarded show-ahead response FIFO.
module cordic_rr_scheduler #(
   parameter int NREQ       = 4,
   parameter int IDW        = 2,
   parameter int LATENCY    = 16,
   parameter int FIFO_DEPTH = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [16*NREQ-1:0]   req_x,
   input  logic [16*NREQ-1:0]   req_y,
   input  logic [32*NREQ-1:0]   req_angle,
   output logic [15:0]          cordic_xin,
   output logic [15:0]          cordic_yin,
   output logic [31:0]          cordic_angle,
   input  logic [15:0]          cordic_xout,
   input  logic [15:0]          cordic_yout,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [15:0]          rsp_x,
   output logic [15:0]          rsp_y,
   output logic                 busy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int EW = IDW + 32;

   logic [CW-1:0]   r_credits;
   logic [IDW-1:0]  r_ptr;
   logic [LATENCY:0] r_tag_v;
   logic [IDW-1:0]  r_tag_id [LATENCY+1];
   logic [15:0]     r_xin;
   logic [15:0]     r_yin;
   logic [31:0]     r_angle;
   logic [EW-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr;
   logic [AW-1:0]   r_rd;
   logic [CW-1:0]   r_count;
   logic            r_rsp_valid;
   logic            r_busy;

   logic [IDW-1:0]  w_ord [NREQ];
   logic [IDW-1:0]  w_gidx;
   logic            w_found;
   logic            w_can_issue;
   logic            w_accept;
   logic [NREQ-1:0] w_grant;
   logic            w_wr;
   logic            w_pop;
   logic [CW-1:0]   w_count_nxt;
   logic [LATENCY:0] w_tag_v_nxt;
   logic [EW-1:0]   w_head;

   function automatic logic [IDW-1:0] wrap_add(
      input logic [IDW-1:0] a,
      input int             b
   );
      int s;
      s = int'(a) + b;
      if (s >= NREQ) s = s - NREQ;
      return s[IDW-1:0];
   endfunction

   // Search order starts at the pointer and wraps around the requesters
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         w_ord[k] = wrap_add(r_ptr, k);
      end
   end

   assign w_can_issue = (r_credits != '0);

   always_comb begin
      w_gidx  = '0;
      w_found = 1'b0;
      w_grant = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && req_valid[w_ord[k]]) begin
            w_found = 1'b1;
            w_gidx  = w_ord[k];
         end
      end
      if (w_found && w_can_issue) w_grant[w_gidx] = 1'b1;
   end

   assign w_accept  = w_found & w_can_issue;
   assign req_ready = w_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= wrap_add(w_gidx, 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xin   <= '0;
         r_yin   <= '0;
         r_angle <= '0;
      end else if (w_accept) begin
         r_xin   <= req_x[w_gidx*16 +: 16];
         r_yin   <= req_y[w_gidx*16 +: 16];
         r_angle <= req_angle[w_gidx*32 +: 32];
      end
   end

   assign cordic_xin   = r_xin;
   assign cordic_yin   = r_yin;
   assign cordic_angle = r_angle;

   // Tag stage LATENCY lines up with the rotator output for that operation
   assign w_tag_v_nxt = {r_tag_v[LATENCY-1:0], w_accept};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_v <= '0;
         for (int i = 0; i <= LATENCY; i++) r_tag_id[i] <= '0;
      end else begin
         r_tag_v     <= w_tag_v_nxt;
         r_tag_id[0] <= w_gidx;
         for (int i = 1; i <= LATENCY; i++) begin
            r_tag_id[i] <= r_tag_id[i-1];
         end
      end
   end

   assign w_wr  = r_tag_v[LATENCY];
   assign w_pop = r_rsp_valid & rsp_ready;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr && !w_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_wr && w_pop) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr] <= {r_tag_id[LATENCY], cordic_xout, cordic_yout};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr        <= '0;
         r_rd        <= '0;
         r_count     <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr <= (r_wr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr + AW'(1);
         end
         if (w_pop) begin
            r_rd <= (r_rd == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd + AW'(1);
         end
         r_count     <= w_count_nxt;
         r_rsp_valid <= (w_count_nxt != '0);
      end
   end

   assign w_head    = r_mem[r_rd];
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = w_head[EW-1:32];
   assign rsp_x     = w_head[31:16];
   assign rsp_y     = w_head[15:0];

   // Credits cover both in-flight and buffered results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credits <= CW'(FIFO_DEPTH);
      end else begin
         unique case ({w_accept, w_pop})
            2'b10:   r_credits <= r_credits - CW'(1);
            2'b01:   r_credits <= r_credits + CW'(1);
            default: r_credits <= r_credits;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= (|w_tag_v_nxt) | (w_count_nxt != '0);
      end
   end

   assign busy = r_busy;

   a_no_overflow : assert property (
      @(posedge clk) disable iff (!rst_n)
      !(w_wr && (r_count == CW'(FIFO_DEPTH)))
   );

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: behavioural rotator, scoreboard model,
// arbitration table and directed multi-cycle sequences.
module tb_cordic_rr_scheduler;

   localparam int  NREQ  = 4;
   localparam int  IDW   = 2;
   localparam int  LAT   = 16;
   localparam int  DEPTH = 20;
   localparam real K     = 0.9775;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [16*NREQ-1:0]  req_x = '0;
   logic [16*NREQ-1:0]  req_y = '0;
   logic [32*NREQ-1:0]  req_angle = '0;
   logic [15:0]         cordic_xin;
   logic [15:0]         cordic_yin;
   logic [31:0]         cordic_angle;
   logic [15:0]         cordic_xout;
   logic [15:0]         cordic_yout;
   logic                rsp_valid;
   logic                rsp_ready = 1'b0;
   logic [IDW-1:0]      rsp_id;
   logic [15:0]         rsp_x;
   logic [15:0]         rsp_y;
   logic                busy;

   cordic_rr_scheduler #(
      .NREQ(NREQ), .IDW(IDW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_angle(req_angle),
      .cordic_xin(cordic_xin), .cordic_yin(cordic_yin),
      .cordic_angle(cordic_angle),
      .cordic_xout(cordic_xout), .cordic_yout(cordic_yout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic real theta(input logic [31:0] a);
      return real'(a) * 6.283185307179586 / 4294967296.0;
   endfunction

   function automatic int rot_x(input int x, input int y, input logic [31:0] a);
      return int'(K * (real'(x) * $cos(theta(a)) - real'(y) * $sin(theta(a))));
   endfunction

   function automatic int rot_y(input int x, input int y, input logic [31:0] a);
      return int'(K * (real'(x) * $sin(theta(a)) + real'(y) * $cos(theta(a))));
   endfunction

   // Behavioural rotator: 16 register stages after the operand register
   int px [LAT];
   int py [LAT];
   always @(posedge clk) begin
      px[0] <= rot_x($signed(cordic_xin), $signed(cordic_yin), cordic_angle);
      py[0] <= rot_y($signed(cordic_xin), $signed(cordic_yin), cordic_angle);
      for (int i = 1; i < LAT; i++) begin
         px[i] <= px[i-1];
         py[i] <= py[i-1];
      end
   end
   assign cordic_xout = 16'(px[LAT-1]);
   assign cordic_yout = 16'(py[LAT-1]);

   typedef struct { int id; int x; int y; int due; } exp_t;
   typedef struct { int pre; logic [3:0] v; logic [3:0] r; } arb_vec_t;

   exp_t        q[$];
   int          popped_ids[$];
   int          m_ptr, m_out, cyc;
   logic [15:0] m_xin, m_yin;
   logic [31:0] m_ang;
   int          n_chk, n_fail;
   bit          last_acc, last_pop;
   int          last_g, pop_x, pop_y, pop_cyc;

   task automatic chk(input string nm, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_near(input string nm, input int act, input int exp,
                           input int tol);
      n_chk++;
      if (act < exp - tol || act > exp + tol) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d+-%0d", nm, act, exp, tol);
      end
   endtask

   task automatic set_op(input int i, input int x, input int y,
                         input logic [31:0] a);
      req_x[16*i +: 16]     = 16'(x);
      req_y[16*i +: 16]     = 16'(y);
      req_angle[32*i +: 32] = a;
   endtask

   task automatic rand_op(input int i);
      set_op(i, $urandom_range(16000) - 8000, $urandom_range(16000) - 8000,
             $urandom);
   endtask

   // One clock: check against the model, advance the model at the edge
   task automatic step();
      int g;
      int idx;
      logic [NREQ-1:0] er;
      bit erv;
      #1;
      er = '0;
      g  = -1;
      if (m_out < DEPTH) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", req_ready, er);
      erv = (q.size() > 0) && (cyc >= q[0].due);
      chk("rsp_valid", rsp_valid, erv);
      if (erv) begin
         chk("rsp_id", rsp_id, q[0].id);
         chk("rsp_x", $signed(rsp_x), q[0].x);
         chk("rsp_y", $signed(rsp_y), q[0].y);
      end
      last_acc = (g >= 0);
      last_g   = g;
      last_pop = erv && rsp_ready;
      if (last_pop) begin
         pop_x   = $signed(rsp_x);
         pop_y   = $signed(rsp_y);
         pop_cyc = cyc;
         popped_ids.push_back(q[0].id);
      end
      @(posedge clk);
      cyc++;
      if (last_pop) begin
         void'(q.pop_front());
         m_out--;
      end
      if (last_acc) begin
         m_xin = req_x[16*g +: 16];
         m_yin = req_y[16*g +: 16];
         m_ang = req_angle[32*g +: 32];
         q.push_back('{g, rot_x($signed(m_xin), $signed(m_yin), m_ang),
                       rot_y($signed(m_xin), $signed(m_yin), m_ang),
                       cyc + LAT + 1});
         m_out++;
         m_ptr = (g + 1) % NREQ;
      end
      #1;
      chk("cordic_xin", cordic_xin, m_xin);
      chk("cordic_yin", cordic_yin, m_yin);
      chk("cordic_angle", cordic_angle, m_ang);
      chk("busy", busy, q.size() != 0);
      @(negedge clk);
   endtask

   task automatic do_reset(input int ncyc);
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      chk("rst_xin", cordic_xin, 0);
      chk("rst_yin", cordic_yin, 0);
      chk("rst_angle", cordic_angle, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      repeat (ncyc) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      m_ptr = 0;
      m_out = 0;
      m_xin = '0;
      m_yin = '0;
      m_ang = '0;
   endtask

   task automatic drain();
      int n;
      n         = 0;
      req_valid = '0;
      rsp_ready = 1'b1;
      while (q.size() > 0 && n < 200) begin
         step();
         n++;
      end
   endtask

   task automatic single_op(input int id, input int x, input int y,
                            input logic [31:0] a, output int lat,
                            output int rid, output int rx, output int ry);
      set_op(id, x, y, a);
      req_valid = 4'(1 << id);
      rsp_ready = 1'b1;
      step();
      req_valid = '0;
      lat = -1;
      rid = -1;
      rx  = 0;
      ry  = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (rsp_valid && lat < 0) begin
            lat = k;
            rid = rsp_id;
            rx  = $signed(rsp_x);
            ry  = $signed(rsp_y);
         end
         step();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      arb_vec_t    tbl [8];
      logic [31:0] angs [4];
      int          gx [4];
      int          gy [4];
      logic [3:0]  pend;
      int lat, rid, rx, ry, cnt, pops, last_cyc;

      tbl[0] = '{3, 4'b0000, 4'b0000};
      tbl[1] = '{3, 4'b1111, 4'b0001};
      tbl[2] = '{0, 4'b1101, 4'b0100};
      tbl[3] = '{1, 4'b0011, 4'b0001};
      tbl[4] = '{2, 4'b0110, 4'b0010};
      tbl[5] = '{2, 4'b1000, 4'b1000};
      tbl[6] = '{1, 4'b0100, 4'b0100};
      tbl[7] = '{0, 4'b0001, 4'b0001};
      angs = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
      gx   = '{7820, 0, -7820, 0};
      gy   = '{0, 7820, 0, -7820};
      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;

      @(negedge clk);
      do_reset(3);

      // All four requesters for eight cycles from pointer 0
      for (int i = 0; i < NREQ; i++) rand_op(i);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      popped_ids.delete();
      for (int k = 0; k < 8; k++) begin
         step();
         chk("t2_grant", last_g, k % NREQ);
         if (last_acc) rand_op(last_g);
      end
      drain();
      chk("t2_nresp", popped_ids.size(), 8);
      for (int k = 0; k < 8 && k < popped_ids.size(); k++) begin
         chk("t2_resp_id", popped_ids[k], k % NREQ);
      end

      // Arbitration table: preset pointer, then probe a valid pattern
      foreach (tbl[t]) begin
         rand_op(tbl[t].pre);
         req_valid = 4'(1 << tbl[t].pre);
         step();
         req_valid = tbl[t].v;
         #1;
         chk("arb_table", req_ready, tbl[t].r);
         req_valid = '0;
      end
      drain();

      single_op(2, 10000, 0, 32'h2000_0000, lat, rid, rx, ry);
      chk("t1_latency", lat, 17);
      chk("t1_id", rid, 2);
      chk_near("t1_x", rx, 6913, 16);
      chk_near("t1_y", ry, 6913, 16);

      // Four back-to-back quadrant rotations from requester 0
      cnt = 0;
      for (int k = 0; k < 12 && cnt < 4; k++) begin
         set_op(0, 8000, 0, angs[cnt]);
         req_valid = 4'b0001;
         step();
         if (last_acc) cnt++;
      end
      req_valid = '0;
      pops      = 0;
      last_cyc  = -1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (last_pop && pops < 4) begin
            chk_near("t6_x", pop_x, gx[pops], 16);
            chk_near("t6_y", pop_y, gy[pops], 16);
            if (pops > 0) chk("t6_consecutive", pop_cyc - last_cyc, 1);
            last_cyc = pop_cyc;
            pops++;
         end
      end
      chk("t6_npops", pops, 4);

      // Reset in mid-flight discards everything
      for (int i = 0; i < NREQ; i++) rand_op(i);
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         if (last_acc) rand_op(last_g);
      end
      do_reset(2);
      req_valid = '0;
      for (int k = 0; k < 30; k++) step();
      single_op(1, -3000, 4000, 32'h1234_5678, lat, rid, rx, ry);
      chk("t5_latency", lat, 17);
      chk("t5_id", rid, 1);
      drain();

      // Credit exhaustion with the consumer stalled
      for (int i = 0; i < NREQ; i++) rand_op(i);
      req_valid = 4'b1111;
      rsp_ready = 1'b0;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (last_acc) begin
            cnt++;
            rand_op(last_g);
         end
      end
      chk("t3_accepts", cnt, DEPTH);
      rsp_ready = 1'b1;
      step();
      chk("t3_one_pop", last_pop, 1);
      cnt = last_acc ? 1 : 0;
      if (last_acc) rand_op(last_g);
      rsp_ready = 1'b0;
      for (int k = 0; k < 25; k++) begin
         step();
         if (last_acc) begin
            cnt++;
            rand_op(last_g);
         end
      end
      chk("t3_extra_accepts", cnt, 1);

      // Full FIFO, zero credits: pop and accept overlap continuously
      rsp_ready = 1'b1;
      cnt  = 0;
      pops = 0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (last_acc) begin
            cnt++;
            rand_op(last_g);
         end
         if (last_pop) pops++;
      end
      chk("t4_accepts", cnt, 59);
      chk("t4_pops", pops, 60);
      drain();

      // Randomized traffic, requesters hold operands until accepted
      pend = '0;
      for (int k = 0; k < 500; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i] = 1'b1;
               rand_op(i);
            end
         end
         req_valid = pend;
         rsp_ready = ($urandom_range(3) != 0);
         step();
         if (last_acc) pend[last_g] = 1'b0;
      end
      drain();
      step();
      chk("final_rsp_valid", rsp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
